mc_controller: RTL
==================

# mc_controller

Multicycle control sequencer for the MIPS-subset datapath. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, holding a shared single-port memory through a req/ack handshake. Drives every datapath control input, plus the PC enable, IR load and memory-select strobes needed when the PC and IR registers are enable-gated. Sits between the datapath and the unified instruction/data memory.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `instruction`  in  32  IR contents; opcode is [31:26], funct is [5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ack`  in  1  memory completed the current access.
- `mem_req`, `mem_we`, `i_or_d`  out  1 each  memory request, write strobe, address select (0 = PC, 1 = ALU).
- `ir_write`, `pc_en`  out  1 each  IR load, PC register enable.
- `mem_to_reg`, `pc_src`, `alu_src`, `reg_write`, `noExt`, `jal`  out  1 each  datapath controls.
- `jump`, `reg_dst`  out  2 each  datapath mux selects.
- `alu_control`  out  4  ALU operation code.
- `retired`  out  32  count of committed instructions.
- `trap`  out  1  only when `MC_CTRL_TRAP_EN` is defined.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, and TRAP (macro only).
- All outputs are Moore-decoded from the state and a decode register.
- IDLE:
  - All outputs are 0.
  - Always moves to FETCH on the next cycle.
- FETCH:
  - `mem_req=1`, `i_or_d=0`.
  - Stays in FETCH until `mem_ack`.
  - On the ack cycle, `ir_write=1` and the next state is DECODE.
- DECODE:
  - One cycle.
  - Latches the control word from the opcode/funct decode. Later changes to `instruction` have no effect.
- EXEC commits (`pc_en=1`, then goes to FETCH) for these instructions:
  - beq: `alu_control=SUB`, `pc_src=zero`.
  - j: `jump=10`.
  - jr: `jump=01`.
  - jal: `jump=10`, `jal=1`, `reg_dst=10`, `reg_write=1`.
- EXEC for all other instructions:
  - Drives `alu_src`, `noExt` and `alu_control`.
  - Goes to MEM for lw/sw, otherwise to WB.
- MEM:
  - `mem_req=1`, `i_or_d=1`, `mem_we=1` for sw. Waits for `mem_ack`.
  - sw commits on the ack cycle (`pc_en=1`, then FETCH).
  - lw goes to WB.
- WB:
  - `reg_write=1`, `pc_en=1`, then FETCH.
  - `mem_to_reg=1` for lw.
  - `reg_dst=01` for R-type, 00 for I-type.
- ALU operation codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111.
- Decode map:
  - R-type (opcode 000000) by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr.
  - Opcodes: lw 100011, sw 101011, beq 000100, addi 001000, andi 001100 (`noExt=1`), ori 001101 (`noExt=1`), j 000010, jal 000011.
  - lw, sw and addi use ADD with `alu_src=1`.
- `pc_en` asserts exactly once per instruction, on its commit cycle.
- `retired` increments on every `pc_en` cycle and wraps from 0xFFFFFFFF to 0.
- Illegal opcode/funct without the macro: treated as NOP. EXEC commits with only `pc_en=1` and `retired` increments.

## Timing
- Reset is asynchronous. While `reset` is high:
  - state is IDLE, all outputs are 0, `retired` is 0.
  - This holds mid-handshake as well; an outstanding memory access is abandoned.
- First `mem_req` appears 2 cycles after reset deasserts: one cycle in IDLE, then FETCH.
- `mem_req` stays high, with `i_or_d`/`mem_we` stable, until the cycle `mem_ack` is sampled high.
- `mem_ack` is ignored while `mem_req` is low.
- An ack in the same cycle as the request is legal (zero-wait memory).
- Latency with zero-wait memory:
  - branch/jump: 3 cycles.
  - R-type, I-type ALU and sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
- `reg_write` and `pc_en` can assert in the same cycle (WB, jal). The register file samples the pre-update PC.

## Configuration
- `MC_CTRL_TRAP_EN` defined:
  - An illegal opcode/funct moves DECODE to TRAP.
  - TRAP holds `trap=1` with all other outputs 0, and the PC does not advance.
  - TRAP exits only on reset.
  - `retired` does not count the illegal instruction.
- `MC_CTRL_TRAP_EN` undefined: NOP behaviour as described in Operation. The `trap` port is absent.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum;
  - opcode/funct localparams;
  - ALU code localparams;
  - a packed control-word struct (`mem_to_reg` … `alu_control`, plus `is_mem`, `is_store`, `is_jump_class`, `illegal`).
- Sub-module `mc_decode`: purely combinational map from opcode/funct to the control word. Instantiated once and latched in DECODE.

## Test plan
- Reset high mid-FETCH with `mem_req=1` → all outputs 0 immediately. After release: IDLE for 1 cycle, `mem_req=1` the cycle after.
- Zero-wait add (0x012A4020) → `ir_write` on cycle 1; WB at cycle 4 with `reg_dst=01`, `reg_write=1`, `alu_control=0010`, `pc_en=1`; `retired`=1.
- lw with `mem_ack` delayed 3 cycles in MEM → `mem_req`, `i_or_d=1` held 4 cycles. WB has `mem_to_reg=1`, `reg_dst=00`. Total 8 cycles.
- beq with `zero=1`, then beq with `zero=0` → EXEC shows `pc_src` 1 then 0, `alu_control=0110`, `pc_en=1`, 3 cycles each.
- jal (0x0C000010) → EXEC: `jump=10`, `jal=1`, `reg_dst=10`, `reg_write=1`, `pc_en=1` in a single cycle.
- Opcode 111111:
  - with macro → `trap=1` held, `retired` frozen, no further `mem_req`.
  - without macro → single `pc_en` in EXEC, `retired`+1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state encoding, opcode/funct/ALU constants and the latched control word for mc_controller
// Optional feature macro: MC_CTRL_TRAP_EN adds the TRAP state.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB
`ifdef MC_CTRL_TRAP_EN
    , TRAP
`endif
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef struct packed {
    logic       mem_to_reg;
    logic       is_branch;
    logic       alu_src;
    logic       reg_write;
    logic       no_ext;
    logic       jal;
    logic [1:0] jump;
    logic [1:0] reg_dst;
    logic [3:0] alu_control;
    logic       is_mem;
    logic       is_store;
    logic       is_jump_class;
    logic       illegal;
  } ctrl_t;
  function automatic ctrl_t r_op(input logic [3:0] alu);
    r_op = '0;
    r_op.reg_write = 1'b1;
    r_op.reg_dst = 2'b01;
    r_op.alu_control = alu;
  endfunction
  function automatic ctrl_t i_op(input logic [3:0] alu, input logic ne);
    i_op = '0;
    i_op.alu_src = 1'b1;
    i_op.reg_write = 1'b1;
    i_op.no_ext = ne;
    i_op.alu_control = alu;
  endfunction
  function automatic ctrl_t jmp_op(input logic [1:0] j);
    jmp_op = '0;
    jmp_op.jump = j;
    jmp_op.is_jump_class = 1'b1;
  endfunction
endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: combinational opcode/funct to control-word map
// Ports: opcode [5:0], funct [5:0] in; cw (ctrl_t) out. Unrecognised encodings set only cw.illegal.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      cw
);
  always_comb begin
    cw = '0;
    cw.illegal = 1'b1;
    case (opcode)
      OP_RTYPE:
        case (funct)
          FN_ADD: cw = r_op(ALU_ADD);
          FN_SUB: cw = r_op(ALU_SUB);
          FN_AND: cw = r_op(ALU_AND);
          FN_OR:  cw = r_op(ALU_OR);
          FN_SLT: cw = r_op(ALU_SLT);
          FN_JR:  cw = jmp_op(2'b01);
          default: ;
        endcase
      OP_LW: begin
        cw = i_op(ALU_ADD, 1'b0);
        cw.is_mem = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        cw = i_op(ALU_ADD, 1'b0);
        cw.reg_write = 1'b0;
        cw.is_mem = 1'b1;
        cw.is_store = 1'b1;
      end
      OP_BEQ: begin
        cw = jmp_op(2'b00);
        cw.is_branch = 1'b1;
        cw.alu_control = ALU_SUB;
      end
      OP_ADDI: cw = i_op(ALU_ADD, 1'b0);
      OP_ANDI: cw = i_op(ALU_AND, 1'b1);
      OP_ORI:  cw = i_op(ALU_OR, 1'b1);
      OP_J:    cw = jmp_op(2'b10);
      OP_JAL: begin
        cw = jmp_op(2'b10);
        cw.jal = 1'b1;
        cw.reg_dst = 2'b10;
        cw.reg_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath
// Ports: clk, reset (async, active-high); instruction[31:0], zero, mem_ack in;
//   mem_req, mem_we, i_or_d, ir_write, pc_en, mem_to_reg, pc_src, alu_src, reg_write,
//   noExt, jal, jump[1:0], reg_dst[1:0], alu_control[3:0], retired[31:0] out;
//   trap out only when MC_CTRL_TRAP_EN is defined (illegal encodings then park in TRAP).
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_en,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        noExt,
  output logic        jal,
  output logic [1:0]  jump,
  output logic [1:0]  reg_dst,
  output logic [3:0]  alu_control,
  output logic [31:0] retired
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic        trap
`endif
);
  state_t state;
  ctrl_t  cw, dec;
  logic   fe, ex, mm, wb, jc, alu_act, unused_instr;
  assign unused_instr = ^instruction[25:6];
  mc_decode u_decode (.opcode(instruction[31:26]), .funct(instruction[5:0]), .cw(dec));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cw <= '0;
      retired <= '0;
    end else begin
      retired <= retired + 32'(pc_en);
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  state <= mem_ack ? DECODE : FETCH;
`ifdef MC_CTRL_TRAP_EN
        DECODE: begin cw <= dec; state <= dec.illegal ? TRAP : EXEC; end
`else
        DECODE: begin cw <= dec; state <= EXEC; end
`endif
        EXEC:   state <= (cw.is_jump_class | cw.illegal) ? FETCH : cw.is_mem ? MEM : WB;
        MEM:    state <= mem_ack ? (cw.is_store ? FETCH : WB) : MEM;
        WB:     state <= FETCH;
        default: state <= state;
      endcase
    end
  assign fe = state == FETCH;
  assign ex = state == EXEC;
  assign mm = state == MEM;
  assign wb = state == WB;
  assign jc = ex & cw.is_jump_class;
  // No ALU output register in the datapath: hold the ALU setup until the result is consumed.
  assign alu_act = ex | mm | wb;
  assign mem_req = fe | mm;
  assign i_or_d = mm;
  assign mem_we = mm & cw.is_store;
  assign ir_write = fe & mem_ack;
  assign alu_src = alu_act & cw.alu_src;
  assign noExt = alu_act & cw.no_ext;
  assign alu_control = alu_act ? cw.alu_control : 4'b0000;
  assign jump = jc ? cw.jump : 2'b00;
  assign jal = jc & cw.jal;
  assign pc_src = jc & cw.is_branch & zero;
  assign reg_dst = (jc | wb) ? cw.reg_dst : 2'b00;
  assign reg_write = (jc & cw.reg_write) | wb;
  assign mem_to_reg = wb & cw.mem_to_reg;
  // Illegal encodings only reach EXEC in the NOP build, where they commit immediately.
  assign pc_en = (ex & (cw.is_jump_class | cw.illegal)) | (mm & cw.is_store & mem_ack) | wb;
`ifdef MC_CTRL_TRAP_EN
  assign trap = state == TRAP;
`endif
endmodule
